fpa_arbiter: RTL and testbench

//  Shares one combinational fpu adder (in1/in2 -> out, 32-bit team float: sign[31], exp[30:23],

---
 rtl/fpa_arbiter_pkg.sv | 15 +
 rtl/fpa_arbiter_fpu.sv | 56 +++++
 rtl/fpa_arbiter_rr.sv | 42 ++++
 rtl/fpa_arbiter.sv | 120 ++++++++++++
 tb/tb_fpa_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpa_arbiter_pkg.sv
// rtl/fpa_arbiter_pkg.sv - shared constants and FSM encoding for the fpu arbiter
package fpa_arbiter_pkg;

    localparam int DATA_W   = 32;
    localparam int SIGN_BIT = 31;
    localparam int EXP_W    = 8;
    localparam int MANT_W   = 23;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/fpa_arbiter_fpu.sv
// rtl/fpa_arbiter_fpu.sv - combinational adder for the team float format
// in1, in2 : operands {sign, exp[7:0] unbiased, mantissa[22:0] with explicit leading one}
// out      : truncated sum; exact zero is returned as all-zero
module fpu
    import fpa_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
    output logic [DATA_W-1:0] out
);

    logic              s_l, s_s, found;
    logic [EXP_W-1:0]  e_l, e_s, diff, e_r;
    logic [MANT_W-1:0] m_l, m_s, m_r;
    logic [MANT_W:0]   m_s_al, mag;
    logic [4:0]        lz;

    always_comb begin
        // {exp, mantissa} orders magnitudes directly, so pick the larger one first.
        if (in1[DATA_W-2:0] >= in2[DATA_W-2:0]) begin
            {s_l, e_l, m_l} = in1;
            {s_s, e_s, m_s} = in2;
        end else begin
            {s_l, e_l, m_l} = in2;
            {s_s, e_s, m_s} = in1;
        end
        diff   = e_l - e_s;
        m_s_al = {1'b0, m_s} >> diff;
        if (s_l == s_s) begin
            mag = {1'b0, m_l} + m_s_al;
        end else begin
            mag = {1'b0, m_l} - m_s_al;
        end
        lz    = '0;
        found = 1'b0;
        for (int i = MANT_W - 1; i >= 0; i--) begin
            if (!found && mag[i]) begin
                lz    = 5'(MANT_W - 1 - i);
                found = 1'b1;
            end
        end
        if (mag[MANT_W]) begin
            m_r = mag[MANT_W:1];
            e_r = e_l + 8'd1;
        end else begin
            m_r = mag[MANT_W-1:0] << lz;
            e_r = e_l - {3'b000, lz};
        end
        if (mag == '0) begin
            out = '0;
        end else begin
            out = {s_l, e_r, m_r};
        end
    end

endmodule

// File: rtl/fpa_arbiter_rr.sv
// rtl/fpa_arbiter_rr.sv - combinational round-robin picker
// req_i      : request vector
// ptr_i      : index with highest priority this cycle
// gnt_o      : one-hot grant (zero when no request)
// gnt_id_o   : encoded grant index
// gnt_any_o  : any request present
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    gnt_id_o,
    output logic               gnt_any_o
);

    int              pos;
    logic [ID_W-1:0] idx;

    // Scan from the pointer upward, wrapping; the first hit wins.
    always_comb begin
        gnt_o     = '0;
        gnt_id_o  = '0;
        gnt_any_o = 1'b0;
        pos       = 0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = int'(ptr_i) + k;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            idx = ID_W'(pos);
            if (!gnt_any_o && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                gnt_id_o   = idx;
                gnt_any_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpa_arbiter.sv
// rtl/fpa_arbiter.sv - round-robin sharing of one fpu adder among NUM_REQ requesters
// clk, rst            : clock, synchronous active-high reset
// req_valid/req_ready : per-requester handshake, ready one-hot or zero
// req_a, req_b        : packed operands, requester i at [i*DATA_W +: DATA_W]
// req_sub             : per-requester subtract select
// rsp_valid/rsp_ready : result handshake
// rsp_sum, rsp_id     : registered result and issuing requester
// busy                : high outside IDLE
module fpa_arbiter
    import fpa_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ-1:0]        req_sub,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_W-1:0]         rsp_sum,
    output logic [ID_W-1:0]           rsp_id,
    output logic                      busy
);

    state_e             state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [ID_W-1:0]    id_q, rsp_id_q;
    logic [DATA_W-1:0]  op_a_q, op_b_q, sum_q;
    logic [DATA_W-1:0]  sel_a, sel_b, fpu_out;
    logic               rsp_valid_q;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_id;
    logic               gnt_any;
    logic               accept;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req_i     (req_valid),
        .ptr_i     (ptr_q),
        .gnt_o     (gnt),
        .gnt_id_o  (gnt_id),
        .gnt_any_o (gnt_any)
    );

    fpu u_fpu (
        .in1 (op_a_q),
        .in2 (op_b_q),
        .out (fpu_out)
    );

    // A grant in IDLE is itself the handshake: ready is the grant.
    assign accept = (state_q == ST_IDLE) && gnt_any;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (gnt_any)   state_d = ST_EXEC;
            ST_EXEC:                state_d = ST_DONE;
            ST_DONE: if (rsp_ready) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == ST_IDLE) ? gnt : '0;
        busy      = (state_q != ST_IDLE);
        rsp_valid = rsp_valid_q;
        rsp_sum   = sum_q;
        rsp_id    = rsp_id_q;
    end

    always_comb begin
        sel_a           = req_a[gnt_id*DATA_W +: DATA_W];
        sel_b           = req_b[gnt_id*DATA_W +: DATA_W];
        sel_b[SIGN_BIT] = sel_b[SIGN_BIT] ^ req_sub[gnt_id];
        ptr_d           = (int'(gnt_id) == NUM_REQ - 1) ? '0 : gnt_id + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            id_q        <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            sum_q       <= '0;
            rsp_id_q    <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                op_a_q <= sel_a;
                op_b_q <= sel_b;
                id_q   <= gnt_id;
                ptr_q  <= ptr_d;
            end
            if (state_q == ST_EXEC) begin
                sum_q       <= fpu_out;
                rsp_id_q    <= id_q;
                rsp_valid_q <= 1'b1;
            end
            if (state_q == ST_DONE && rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fpa_arbiter.sv
// tb/tb_fpa_arbiter.sv - self-checking bench for fpa_arbiter
module tb_fpa_arbiter;

    localparam int N   = 4;
    localparam int W   = 32;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a = '0;
    logic [N*W-1:0] req_b = '0;
    logic [N-1:0]   req_sub = '0;
    logic           rsp_valid;
    logic           rsp_ready = 1'b0;
    logic [W-1:0]   rsp_sum;
    logic [IDW-1:0] rsp_id;
    logic           busy;

    always #5 clk = ~clk;

    fpa_arbiter #(.NUM_REQ(N), .ID_W(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sub   (req_sub),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Value = (-1)^s * mant * 2^(exp-22); computed exactly relative to the smaller exponent.
    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b, input logic sub);
        logic [31:0] bb, r;
        int          ea, eb, emin, p;
        longint      va, vb, s, mag;
        bb = b;
        if (sub) bb[31] = ~bb[31];
        if (a[22:0] == 0 && bb[22:0] == 0) return 32'h0;
        if (a[22:0] == 0) return bb;
        if (bb[22:0] == 0) return a;
        ea   = int'(a[30:23]);
        eb   = int'(bb[30:23]);
        emin = (ea < eb) ? ea : eb;
        va   = longint'(a[22:0]) <<< (ea - emin);
        vb   = longint'(bb[22:0]) <<< (eb - emin);
        if (a[31])  va = -va;
        if (bb[31]) vb = -vb;
        s = va + vb;
        if (s == 0) return 32'h0;
        mag = (s < 0) ? -s : s;
        p = 0;
        for (int i = 0; i < 62; i++) if (mag[i]) p = i;
        r[31]    = (s < 0);
        r[30:23] = 8'(emin + p - 22);
        r[22:0]  = (p >= 22) ? 23'(mag >>> (p - 22)) : 23'(mag <<< (22 - p));
        return r;
    endfunction

    function automatic int ref_pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [31:0] rnd_fp(input int e);
        logic [31:0] r;
        r        = $urandom;
        r[7:0]   = 8'h00;
        r[22]    = 1'b1;
        r[30:23] = e[7:0];
        return r;
    endfunction

    // Reference model state: one operation in flight at most.
    bit           mon_en     = 1'b0;
    bit           m_inflight = 1'b0;
    int           m_age      = 0;
    int           m_ptr      = 0;
    logic [31:0]  m_sum      = '0;
    int           m_id       = 0;
    bit           m_fresh    = 1'b0;
    int           m_g;
    logic [N-1:0] m_exp_ready;
    logic [N-1:0] seen_ready = '0;

    always @(negedge clk) begin
        seen_ready  = req_ready;
        m_g         = ref_pick(req_valid, m_ptr);
        m_exp_ready = (m_inflight || m_g < 0) ? '0 : N'(1 << m_g);
        if (mon_en) begin
            chk("mon_busy", busy, m_inflight);
            chk("mon_rsp_valid", rsp_valid, m_inflight && m_age >= 1);
            chk("mon_req_ready", req_ready, m_exp_ready);
            if (m_inflight && m_age >= 1) begin
                chk("mon_rsp_sum", rsp_sum, m_sum);
                chk("mon_rsp_id", rsp_id, m_id);
            end
            if (m_fresh) begin
                chk("mon_rst_sum", rsp_sum, 0);
                chk("mon_rst_id", rsp_id, 0);
            end
        end
        if (rst) begin
            m_inflight = 1'b0;
            m_age      = 0;
            m_ptr      = 0;
            m_fresh    = 1'b1;
            mon_en     = 1'b1;
        end else if (!m_inflight) begin
            if (m_g >= 0) begin
                m_inflight = 1'b1;
                m_age      = 0;
                m_sum      = ref_add(req_a[m_g*W +: W], req_b[m_g*W +: W], req_sub[m_g]);
                m_id       = m_g;
                m_ptr      = (m_g + 1) % N;
            end
        end else if (m_age >= 1 && rsp_ready) begin
            m_inflight = 1'b0;
        end else begin
            m_fresh = 1'b0;
            m_age   = 1;
        end
    end

    task automatic run_one(input string nm, input int idx, input logic [31:0] a,
                           input logic [31:0] b, input logic sub, input logic [31:0] exp_sum);
        tick();
        req_a[idx*W +: W] = a;
        req_b[idx*W +: W] = b;
        req_sub[idx]      = sub;
        req_valid         = N'(1 << idx);
        rsp_ready         = 1'b1;
        @(negedge clk);
        chk({nm, "_ready"}, req_ready, 1 << idx);
        tick();
        req_valid = '0;
        @(negedge clk);
        chk({nm, "_exec_valid"}, rsp_valid, 0);
        chk({nm, "_exec_busy"}, busy, 1);
        tick();
        @(negedge clk);
        chk({nm, "_rsp_valid"}, rsp_valid, 1);
        chk({nm, "_sum"}, rsp_sum, exp_sum);
        chk({nm, "_id"}, rsp_id, idx);
        tick();
        @(negedge clk);
        chk({nm, "_idle"}, busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int gidx[$];
        int gcyc[$];
        logic [31:0] ra, rb;
        int ea, eb;
        bit hold;

        chk("pin_add", ref_add(32'h01CE0000, 32'h024A4000, 1'b0), 32'h02714000);
        chk("pin_sub", ref_add(32'h01CE0000, 32'h024A4000, 1'b1), 32'h81C68000);
        chk("pin_add2", ref_add(32'h01540000, 32'h00600000, 1'b0), 32'h016C0000);
        chk("pin_zero", ref_add(32'h0, 32'h0, 1'b0), 32'h0);

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_sum", rsp_sum, 0);

        run_one("t1", 0, 32'h01CE0000, 32'h024A4000, 1'b0, 32'h02714000);
        run_one("t2", 0, 32'h01CE0000, 32'h024A4000, 1'b1, 32'h81C68000);

        // All requesters held valid after a reset: rotation 0,1,2,3,0 at one op per 3 cycles.
        tick();
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        req_a     = {N{32'h01CE0000}};
        req_b     = {N{32'h024A4000}};
        req_sub   = '0;
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (req_ready != 0) begin
                chk("t3_onehot", $onehot(req_ready), 1);
                gidx.push_back($clog2(req_ready));
                gcyc.push_back(c);
            end
            tick();
        end
        req_valid = '0;
        chk("t3_count", gidx.size() >= 5, 1);
        for (int k = 0; k < 5 && k < gidx.size(); k++) chk("t3_order", gidx[k], k % 4);
        for (int k = 1; k < 5 && k < gcyc.size(); k++) chk("t3_gap", gcyc[k] - gcyc[k-1], 3);
        repeat (5) tick();

        // Back-pressure: result held while rsp_ready is low, even with another request waiting.
        req_a[2*W +: W] = 32'h01540000;
        req_b[2*W +: W] = 32'h00600000;
        req_sub[2]      = 1'b0;
        req_valid       = 4'b0100;
        rsp_ready       = 1'b0;
        @(negedge clk);
        chk("t4_ready", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("t4_rsp_valid", rsp_valid, 1);
        for (int c = 0; c < 5; c++) begin
            tick();
            req_valid = 4'b0001;
            @(negedge clk);
            chk("t4_hold_valid", rsp_valid, 1);
            chk("t4_hold_sum", rsp_sum, 32'h016C0000);
            chk("t4_hold_id", rsp_id, 2);
            chk("t4_hold_ready", req_ready, 0);
        end
        tick();
        req_valid = '0;
        rsp_ready = 1'b1;
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("t4_idle_busy", busy, 0);
        chk("t4_idle_valid", rsp_valid, 0);

        // Reset during EXEC drops the op and restores requester 0 priority.
        tick();
        req_valid = 4'b0010;
        @(negedge clk);
        chk("t5_ready", req_ready, 4'b0010);
        tick();
        req_valid = '0;
        rst       = 1'b1;
        @(negedge clk);
        chk("t5_exec_busy", busy, 1);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t5_busy", busy, 0);
        chk("t5_rsp_valid", rsp_valid, 0);
        for (int c = 0; c < 3; c++) begin
            tick();
            @(negedge clk);
            chk("t5_noresp", rsp_valid, 0);
        end
        tick();
        req_valid = 4'b0111;
        @(negedge clk);
        chk("t5_grant0", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        repeat (5) tick();

        run_one("t6", 3, 32'h0, 32'h0, 1'b0, 32'h0);
        tick();
        req_valid = '1;
        @(negedge clk);
        chk("t6_wrap", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        repeat (5) tick();

        // Randomized traffic; the monitor model checks every cycle.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            rst       = ($urandom_range(0, 299) == 0);
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                hold = req_valid[i] && !seen_ready[i];
                if (!hold) begin
                    if (req_valid[i]) req_valid[i] = ($urandom_range(0, 1) == 1);
                    else              req_valid[i] = ($urandom_range(0, 9) < 3);
                    ea = int'($urandom_range(23, 200));
                    eb = ea + int'($urandom_range(0, 14)) - 7;
                    ra = rnd_fp(ea);
                    rb = rnd_fp(eb);
                    req_a[i*W +: W] = ra;
                    req_b[i*W +: W] = rb;
                    req_sub[i]      = ($urandom_range(0, 1) == 1);
                end
            end
        end
        tick();
        rst       = 1'b0;
        req_valid = '0;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
